// File: rtl/mem_stage_if.sv
// Data-memory request/ready bus between the MEM stage (master) and data memory (slave).
interface mem_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_size;
  logic [63:0] dmem_addr;
  logic [63:0] dmem_wdata;
  logic [63:0] dmem_rdata;
  logic        dmem_ready;

  modport master (
    output dmem_req, dmem_we, dmem_size, dmem_addr, dmem_wdata,
    input  dmem_rdata, dmem_ready
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_size, dmem_addr, dmem_wdata,
    output dmem_rdata, dmem_ready
  );
endinterface

// File: rtl/mem_stage.sv
// EX/MEM pipeline register plus data-memory access controller (IDLE/REQ/DONE).
// Optional REQ timeout with sticky MemErr is enabled by defining MEM_TIMEOUT_EN.
module mem_stage #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  ExAw,
  input  logic [63:0] ExALUOut,
  input  logic [63:0] ExStoreData,
  input  logic        ExRegWrite,
  input  logic        ExMem2Reg,
  input  logic        ExMemRead,
  input  logic        ExMemWrite,
  input  logic        ExByte,
  output logic [4:0]  MemAw,
  output logic [63:0] MemALUOut,
  output logic [63:0] MemOut,
  output logic        MemRegWrite,
  output logic        MemMem2Reg,
  output logic        MemStall,
  mem_stage_if.master dmem,
  output logic        MemErr
);

  if (TIMEOUT_CYCLES < 1) begin : g_timeout_check
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t      state_q, state_d;
  logic [4:0]  aw_q, aw_d;
  logic [63:0] alu_q, alu_d;
  logic [63:0] sdata_q, sdata_d;
  logic [63:0] mem_out_q, mem_out_d;
  logic        reg_write_q, reg_write_d;
  logic        mem2reg_q, mem2reg_d;
  logic        mem_read_q, mem_read_d;
  logic        mem_write_q, mem_write_d;
  logic        byte_sel_q, byte_sel_d;
  logic        timeout_hit;
  logic        abort;
  logic        in_req;

  assign in_req = (state_q == REQ);

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             abort_q, abort_d;

  // The current REQ cycle is the TIMEOUT_CYCLES-th one and memory still has not answered.
  assign timeout_hit = in_req && !dmem.dmem_ready && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d   = (in_req && !dmem.dmem_ready) ? cnt_q + 1'b1 : '0;
    abort_d = timeout_hit;
    err_d   = err_q | timeout_hit;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      err_q   <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      abort_q <= abort_d;
    end
  end

  assign abort  = abort_q;
  assign MemErr = err_q;
`else
  assign timeout_hit = 1'b0;
  assign abort       = 1'b0;
  assign MemErr      = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    aw_d        = aw_q;
    alu_d       = alu_q;
    sdata_d     = sdata_q;
    mem_out_d   = mem_out_q;
    reg_write_d = reg_write_q;
    mem2reg_d   = mem2reg_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    byte_sel_d  = byte_sel_q;
    // Outside REQ the register loads every edge; dmem_ready is irrelevant there.
    if (!in_req) begin
      aw_d        = ExAw;
      alu_d       = ExALUOut;
      sdata_d     = ExStoreData;
      reg_write_d = ExRegWrite;
      mem2reg_d   = ExMem2Reg;
      mem_read_d  = ExMemRead;
      mem_write_d = ExMemWrite;
      byte_sel_d  = ExByte;
      state_d     = (ExMemRead || ExMemWrite) ? REQ : IDLE;
    end else if (dmem.dmem_ready) begin
      state_d = DONE;
      if (mem_read_q) begin
        mem_out_d = byte_sel_q ? {56'b0, dmem.dmem_rdata[7:0]} : dmem.dmem_rdata;
      end
    end else if (timeout_hit) begin
      state_d   = DONE;
      mem_out_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      aw_q        <= '0;
      alu_q       <= '0;
      sdata_q     <= '0;
      mem_out_q   <= '0;
      reg_write_q <= 1'b0;
      mem2reg_q   <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      byte_sel_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      aw_q        <= aw_d;
      alu_q       <= alu_d;
      sdata_q     <= sdata_d;
      mem_out_q   <= mem_out_d;
      reg_write_q <= reg_write_d;
      mem2reg_q   <= mem2reg_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      byte_sel_q  <= byte_sel_d;
    end
  end

  assign MemAw       = aw_q;
  assign MemALUOut   = alu_q;
  assign MemOut      = mem_out_q;
  assign MemMem2Reg  = mem2reg_q;
  assign MemStall    = in_req;
  assign MemRegWrite = reg_write_q && !in_req && !abort;

  assign dmem.dmem_req   = in_req;
  assign dmem.dmem_we    = in_req && mem_write_q;
  assign dmem.dmem_size  = in_req && byte_sel_q;
  assign dmem.dmem_addr  = alu_q;
  assign dmem.dmem_wdata = sdata_q;

endmodule

// File: doc/mem_stage.md
# mem_stage

MEM stage of the 5-stage pipelined CPU: the EX/MEM pipeline register plus a data-memory access controller. It latches results from EX and runs loads and stores over a request/ready handshake to data memory. It stalls the upstream pipeline while an access is outstanding and presents the signals consumed by the MEM/WB register. That register samples every cycle, so this block delivers bubbles (MemRegWrite=0) whenever its outputs are not final.

## Interface
Parameters:
- TIMEOUT_CYCLES, 16, max REQ cycles before abort (used only with MEM_TIMEOUT_EN)

Ports (clk, reset first):
- clk  in  1  single clock; rising edge
- reset  in  1  asynchronous, active-high
- ExAw  in  5  destination register from EX
- ExALUOut  in  64  ALU result / effective address
- ExStoreData  in  64  store data
- ExRegWrite, ExMem2Reg, ExMemRead, ExMemWrite, ExByte  in  1 each  control from EX; ExByte selects 8-bit access
- MemAw  out  5  latched destination register
- MemALUOut  out  64  latched ALU result
- MemOut  out  64  load data
- MemRegWrite  out  1  gated register-write enable
- MemMem2Reg  out  1  latched write-back select
- MemStall  out  1  holds IF/ID/EX and freezes EX/MEM
- dmem_req  out  1  memory request
- dmem_we  out  1  1 = store
- dmem_size  out  1  1 = byte, 0 = doubleword
- dmem_addr  out  64  equals MemALUOut
- dmem_wdata  out  64  latched store data
- dmem_rdata  in  64  read data, valid with dmem_ready
- dmem_ready  in  1  access complete
- MemErr  out  1  sticky timeout flag

## Operation
- EX/MEM register fields: Aw, ALUOut, StoreData, RegWrite, Mem2Reg, MemRead, MemWrite, Byte.
- The register loads on each rising edge when MemStall=0 and holds when MemStall=1.
- FSM states: IDLE, REQ, DONE.
  - IDLE: the current entry has no memory op. Outputs are final. MemStall=0.
  - REQ: entered on the edge that loads an entry with MemRead or MemWrite set. dmem_req=1, dmem_we=MemWrite, dmem_size=Byte. MemStall=1 and MemRegWrite=0.
  - REQ to DONE on the edge where dmem_ready=1.
  - DONE: MemStall=0. MemRegWrite equals the latched RegWrite. MemOut holds the captured read data.
  - DONE exits on the next edge: to REQ if the newly loaded entry is a memory op, otherwise to IDLE.
- IDLE to REQ is likewise decided by the entry loaded on each edge.
- Read capture happens on the REQ to DONE edge.
  - Byte=1: MemOut = {56'b0, dmem_rdata[7:0]}.
  - Byte=0: MemOut = dmem_rdata.
- MemOut holds its value until the next capture. For non-load entries MemOut holds its last value; the MEM/WB mux selects MemALUOut for those.
- dmem_ready is ignored in IDLE and DONE.
- A store with RegWrite=1 is passed through unchanged. Legality is the decoder's concern.

## Timing
- Reset: all EX/MEM fields 0, state IDLE, MemOut 0, MemErr 0.
  - Consequently MemStall=0, dmem_req=0 and every output 0.
- Reset asserted mid-access drops dmem_req asynchronously. The access is abandoned and no data is captured.
- Non-memory op: 1 cycle in MEM.
- Memory op: 1 + N cycles, where N ≥ 1 is the number of REQ cycles up to and including the dmem_ready cycle. The minimum is 2 (REQ, DONE).
- Back-to-back memory ops go DONE to REQ with no IDLE cycle.
- dmem_addr, dmem_wdata, dmem_we and dmem_size are stable for the whole of REQ.

## Configuration
- MEM_TIMEOUT_EN defined:
  - A counter clears on REQ entry and increments each REQ cycle without dmem_ready.
  - When it reaches TIMEOUT_CYCLES, the next edge goes to DONE with MemOut=0, MemRegWrite forced 0 in DONE, and MemErr set.
  - MemErr is sticky until reset.
  - dmem_ready on the same cycle as the limit takes priority: normal completion.
- MEM_TIMEOUT_EN undefined: REQ waits indefinitely. MemErr is tied 0 and the port remains.

## Test plan
- Reset during REQ (dmem_req=1) → dmem_req=0 with no clock edge; after release, all outputs 0 and state IDLE.
- ADD, ExAw=3, ExALUOut=0x10, ExRegWrite=1 → next cycle MemAw=3, MemALUOut=0x10, MemRegWrite=1, MemStall=0, dmem_req=0.
- LDUR (ExMemRead=1, ExRegWrite=1, ExMem2Reg=1, ExAw=5, addr 0x40), dmem_ready high on the 3rd REQ cycle with rdata=0xDEADBEEF_CAFEF00D:
  - 3 cycles of MemStall=1 and MemRegWrite=0, then DONE with MemOut=0xDEADBEEF_CAFEF00D and MemRegWrite=1.
  - The EX/MEM inputs presented during the stall are not loaded.
- LDURB, rdata=0xFFFF_FFFF_FFFF_FFA5 → MemOut=0x0000_0000_0000_00A5.
- STUR then immediately LDUR → REQ (dmem_we=1, wdata held), DONE, REQ (dmem_we=0) with no IDLE between.
- With MEM_TIMEOUT_EN and TIMEOUT_CYCLES=4, dmem_ready never asserted → 4 REQ cycles, then DONE with MemOut=0, MemRegWrite=0, MemErr=1 held until reset.
